// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline-stage register carrying DATA_CH data
// channels plus write-back control (MEM->WB by default).
//
// Handshake: a transfer is accepted on a rising edge where in_valid && in_ready,
// and drained on a rising edge where out_valid && out_ready. The producer holds
// its payload stable while valid is high and ready is low. Entries leave in
// the order they arrived.
//
// Build option: define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a
// registered in_ready. Without it, the stage is a single register whose
// in_ready depends combinationally on out_ready.
//
// An accepted halt is stored with its payload zeroed. It sets the sticky
// halted flag, which blocks further accepts until flush or reset. flush
// empties the stage and takes priority over any same-cycle accept or drain.
module pipe_stage_buf #(
  parameter int DATA_W  = 16,
  parameter int DATA_CH = 4,
  parameter int REG_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W*DATA_CH-1:0] in_data,
  input  logic [REG_W-1:0]          in_writereg,
  input  logic                      in_regwrite,
  input  logic                      in_memtoreg,
  input  logic                      in_halt,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W*DATA_CH-1:0] out_data,
  output logic [REG_W-1:0]          out_writereg,
  output logic                      out_regwrite,
  output logic                      out_memtoreg,
  output logic                      out_halt,
  output logic                      halted,
  output logic [1:0]                count
);

  localparam int DW = DATA_W * DATA_CH;
  // Entry layout: {halt, memtoreg, regwrite, writereg, data}
  localparam int PW = DW + REG_W + 3;

  logic [PW-1:0] in_ent;
  logic [PW-1:0] head_q, head_d;
  logic          halted_q, halted_d;
  logic          acc, drn;

  // Squash the payload of a halt so that it cannot write back anything.
  always_comb begin
    if (in_halt) in_ent = {1'b1, {(PW-1){1'b0}}};
    else         in_ent = {1'b0, in_memtoreg, in_regwrite, in_writereg, in_data};
  end

  assign halted = halted_q;
  assign acc    = in_valid && in_ready;
  assign drn    = out_valid && out_ready;

  // The head payload reaches the outputs only while it is valid.
  assign {out_halt, out_memtoreg, out_regwrite, out_writereg, out_data} =
    out_valid ? head_q : '0;

`ifdef PIPE_STAGE_SKID_EN

  logic [PW-1:0] skid_q, skid_d;
  logic [1:0]    count_q, count_d;
  logic          in_ready_q, in_ready_d;

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign count     = count_q;

  // Next-state for the head/skid pair; the skid slot is only used when the
  // head is occupied and not draining. in_ready is looked ahead from the
  // next-state count, so it does not depend on out_ready this cycle.
  always_comb begin
    head_d   = head_q;
    skid_d   = skid_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (flush) begin
      count_d  = 2'd0;
      halted_d = 1'b0;
    end else begin
      if (acc && in_halt) halted_d = 1'b1;
      case ({acc, drn})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d  = in_ent;
            count_d = 2'd1;
          end else begin
            skid_d  = in_ent;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = skid_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = in_ent;
          end else begin
            head_d = skid_q;
            skid_d = in_ent;
          end
        end
        default: ;
      endcase
    end
    in_ready_d = !halted_d && (count_d != 2'd2);
  end

  // State registers; in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      skid_q     <= '0;
      count_q    <= 2'd0;
      halted_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
      in_ready_q <= in_ready_d;
    end
  end

`else

  logic valid_q, valid_d;
  logic alive_q;

  // alive_q holds in_ready low through reset and up to the first clock edge.
  assign in_ready  = alive_q && !halted_q && (!valid_q || out_ready);
  assign out_valid = valid_q;
  assign count     = {1'b0, valid_q};

  // Next-state for the single-entry register.
  always_comb begin
    head_d   = head_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (flush) begin
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else if (acc) begin
      head_d   = in_ent;
      valid_d  = 1'b1;
      if (in_halt) halted_d = 1'b1;
    end else if (drn) begin
      valid_d  = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      alive_q  <= 1'b1;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf (either build). Inputs change 1 ns after the
// rising edge; the handshakes and outputs are sampled on the falling edge.
module tb_pipe_stage_buf;

  localparam int DATA_W  = 16;
  localparam int DATA_CH = 4;
  localparam int REG_W   = 3;
  localparam int DW      = DATA_W * DATA_CH;
  localparam int PW      = DW + REG_W + 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic [REG_W-1:0]  in_writereg = '0;
  logic              in_regwrite = 1'b0;
  logic              in_memtoreg = 1'b0;
  logic              in_halt = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic [REG_W-1:0]  out_writereg;
  logic              out_regwrite;
  logic              out_memtoreg;
  logic              out_halt;
  logic              halted;
  logic [1:0]        count;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_e;
  int            n_checks = 0;
  int            n_bad = 0;
  int            n_drained = 0;
  int            cyc = 0;
  bit            rnd_rdy = 1'b0;

  pipe_stage_buf #(.DATA_W(DATA_W), .DATA_CH(DATA_CH), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_writereg(in_writereg), .in_regwrite(in_regwrite),
    .in_memtoreg(in_memtoreg), .in_halt(in_halt), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_writereg(out_writereg), .out_regwrite(out_regwrite),
    .out_memtoreg(out_memtoreg), .out_halt(out_halt),
    .halted(halted), .count(count)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference entry: a halt carries no payload.
  function automatic logic [PW-1:0] model(input logic [DW-1:0] d, input logic [REG_W-1:0] wr,
                                          input logic rw, input logic mtr, input logic h);
    if (h) return {1'b1, 2'b00, {REG_W{1'b0}}, {DW{1'b0}}};
    return {1'b0, mtr, rw, wr, d};
  endfunction

  // Random downstream back-pressure when enabled
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard: push on accept, pop and compare on drain
  always @(negedge clk) begin
    if (rst) begin
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_drained++;
          if (exp_q.size() == 0) begin
            check("spurious_out", 64'd1, 64'd0);
          end else begin
            exp_e = exp_q.pop_front();
            check("out_data", out_data, exp_e[DW-1:0]);
            check("out_ctrl", {58'd0, out_halt, out_memtoreg, out_regwrite, out_writereg},
                  {58'd0, exp_e[PW-1:DW]});
          end
        end
        if (!out_valid)
          check("idle_zero", out_data | {58'd0, out_halt, out_memtoreg, out_regwrite, out_writereg}, 64'd0);
        if (in_valid && in_ready)
          exp_q.push_back(model(in_data, in_writereg, in_regwrite, in_memtoreg, in_halt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one transfer and hold it until accepted (bounded).
  task automatic send(input logic [DW-1:0] d, input logic [REG_W-1:0] wr,
                      input logic rw, input logic mtr, input logic h);
    bit got;
    in_valid = 1'b1; in_data = d; in_writereg = wr;
    in_regwrite = rw; in_memtoreg = mtr; in_halt = h;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      tick();
    end
    if (!got) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_halt = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int c0, d0;
    logic [DW-1:0] a_dat;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_payload", out_data, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // First transfer, 1-cycle latency
    out_ready = 1'b1;
    send(64'h1234, 3'd5, 1'b1, 1'b0, 1'b0);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_data_ch0", 64'(out_data[15:0]), 64'h1234);
    check("lat_writereg", 64'(out_writereg), 64'd5);
    check("lat_count", 64'(count), 64'd1);
    idle_in();
    wait_empty();

    // Stream of 8 with no bubbles
    d0 = n_drained;
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send({$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0);
    idle_in();
    check("stream_cycles", 64'(cyc - c0), 64'd8);
    tick();
    check("stream_drains", 64'(n_drained - d0), 64'd8);
    wait_empty();

    // Back-pressure: A, B then C while downstream stalls
    out_ready = 1'b0;
    a_dat = 64'hAAAA_0000_AAAA_0001;
    send(a_dat, 3'd1, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    send(64'hBBBB_0000_BBBB_0002, 3'd2, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 64'hCCCC_0000_CCCC_0003; in_writereg = 3'd3;
    tick(); tick();
    check("skid_count", 64'(count), 64'd2);
`else
    in_valid = 1'b1; in_data = 64'hBBBB_0000_BBBB_0002; in_writereg = 3'd2;
    tick(); tick();
    check("hold_count", 64'(count), 64'd1);
`endif
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("hold_head", out_data, a_dat);
    check("hold_writereg", 64'(out_writereg), 64'd1);
    out_ready = 1'b1;
    send(in_data, in_writereg, 1'b0, 1'b1, 1'b0);
    idle_in();
    wait_empty();

    // Random traffic under random back-pressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send({$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        idle_in();
        tick();
      end
    end
    idle_in();
    rnd_rdy = 1'b0;
    #2;
    out_ready = 1'b1;
    wait_empty();

    // Halt squash and sticky halted
    send({DW{1'b1}}, 3'd7, 1'b1, 1'b1, 1'b1);
    check("halt_out_halt", 64'(out_halt), 64'd1);
    check("halt_out_data", out_data, 64'd0);
    check("halt_regwrite", 64'(out_regwrite), 64'd0);
    check("halt_halted", 64'(halted), 64'd1);
    in_valid = 1'b1; in_halt = 1'b0; in_data = 64'h5555; in_writereg = 3'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_blocks_ready", 64'(in_ready), 64'd0);
    end
    check("halt_drained", 64'(count), 64'd0);
    idle_in();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_clr_halted", 64'(halted), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    wait_empty();

    // Flush while full, with a same-cycle accept and drain
    out_ready = 1'b0;
    send(64'h1111, 3'd1, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    send(64'h2222, 3'd2, 1'b1, 1'b0, 1'b0);
    check("pre_flush_count", 64'(count), 64'd2);
`else
    check("pre_flush_count", 64'(count), 64'd1);
`endif
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h3333; in_writereg = 3'd3; in_regwrite = 1'b1;
    tick();
    flush = 1'b0;
    idle_in();
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_halted", 64'(halted), 64'd0);
    tick();
    check("flush_no_store", 64'(out_valid), 64'd0);

    // Asynchronous reset while holding entries
    out_ready = 1'b0;
    send(64'h4444, 3'd4, 1'b1, 1'b1, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    send(64'h5555, 3'd5, 1'b1, 1'b1, 1'b0);
`endif
    idle_in();
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_payload", out_data | {58'd0, out_halt, out_memtoreg, out_regwrite, out_writereg}, 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("arst_release_ready", 64'(in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
